// File: rtl/ntt_addr_gen_if.sv
// Issue-side bundle between the NTT address generator and the bank input crossbar.
interface ntt_addr_gen_if;
  logic       start;
  logic       stall;
  logic [6:0] b0;
  logic [6:0] b1;
  logic [6:0] b2;
  logic [6:0] b3;
  logic [1:0] sel_a_0;
  logic [1:0] sel_a_1;
  logic [1:0] sel_a_2;
  logic [1:0] sel_a_3;
  logic [3:0] stage;
  logic       valid;
  logic       busy;
  logic       done;

  modport master (
    input  start, stall,
    output b0, b1, b2, b3, sel_a_0, sel_a_1, sel_a_2, sel_a_3, stage, valid, busy, done
  );

  modport slave (
    output start, stall,
    input  b0, b1, b2, b3, sel_a_0, sel_a_1, sel_a_2, sel_a_3, stage, valid, busy, done
  );
endinterface

// File: rtl/ntt_addr_gen.sv
// Conflict-free bank address / bank-select sequencer for a 4-bank, 512-point radix-2 NTT.
// Walks 9 stages x 128 butterfly pairs, with a drain gap between stages and stall hold.
module ntt_addr_gen #(
  parameter int GAP = 4
) (
  input  logic           clk,
  input  logic           rst,
  ntt_addr_gen_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  localparam logic [3:0] GAP_LAST   = 4'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [3:0] LAST_STAGE = 4'd8;
  localparam logic [6:0] LAST_CYCLE = 7'd127;

  state_t     state, state_nxt;
  logic [3:0] s_q, s_nxt;
  logic [6:0] c_q, c_nxt;
  logic [3:0] g_q, g_nxt;
  logic       emit;

  logic [8:0] i0_p0, i1_p0, d_p0;
  logic [8:0] lane_p0 [4];
  logic [1:0] sel_p0  [4];

  logic [6:0] b_p1   [4];
  logic [1:0] sel_p1 [4];
  logic [3:0] stage_p1;
  logic       vld_p1, busy_p1, done_p1;

  // Spread j around a zero at bit s: the low s bits stay, the rest shift up by one.
  function automatic logic [8:0] insert_zero(input logic [7:0] j, input logic [3:0] s);
    logic [8:0] jx, mask;
    jx   = {1'b0, j};
    mask = (9'd1 << s) - 9'd1;
    return ((jx & ~mask) << 1) | (jx & mask);
  endfunction

  function automatic logic [1:0] bank_of(input logic [8:0] x);
    return {x[0], ^x};
  endfunction

  function automatic logic [6:0] addr_of(input logic [8:0] x);
    return x[8:2];
  endfunction

  always_comb begin : fsm_next
    state_nxt = state;
    s_nxt     = s_q;
    c_nxt     = c_q;
    g_nxt     = g_q;
    emit      = 1'b0;
    case (state)
      // done_p1 still high means we are in the done cycle; start is not yet accepted.
      S_IDLE: if (bus.start && !done_p1) begin
        state_nxt = S_RUN;
        s_nxt     = 4'd0;
        c_nxt     = 7'd0;
        g_nxt     = 4'd0;
      end
      S_RUN: if (!bus.stall) begin
        emit  = 1'b1;
        c_nxt = c_q + 7'd1;
        if (c_q == LAST_CYCLE) begin
          if (s_q == LAST_STAGE) begin
            state_nxt = S_DONE;
          end else begin
            s_nxt     = s_q + 4'd1;
            c_nxt     = 7'd0;
            g_nxt     = 4'd0;
            state_nxt = (GAP == 0) ? S_RUN : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (g_q == GAP_LAST) begin
          g_nxt     = 4'd0;
          state_nxt = S_RUN;
        end else begin
          g_nxt = g_q + 4'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin : fsm_state
    if (!rst) begin
      state <= S_IDLE;
      s_q   <= 4'd0;
      c_q   <= 7'd0;
      g_q   <= 4'd0;
    end else begin
      state <= state_nxt;
      s_q   <= s_nxt;
      c_q   <= c_nxt;
      g_q   <= g_nxt;
    end
  end

  // p0: lane indices for butterfly pair (s, c) and the inverse bank permutation
  assign i0_p0 = insert_zero({c_q, 1'b0}, s_q);
  assign i1_p0 = insert_zero({c_q, 1'b1}, s_q);
  assign d_p0  = 9'd1 << s_q;

  always_comb begin : lane_map
    lane_p0[0] = i0_p0;
    lane_p0[1] = i0_p0 + d_p0;
    lane_p0[2] = i1_p0;
    lane_p0[3] = i1_p0 + d_p0;
    for (int k = 0; k < 4; k++) begin
      sel_p0[k] = 2'd0;
      for (int l = 0; l < 4; l++) begin
        if (bank_of(lane_p0[l]) == 2'(k)) sel_p0[k] = 2'(l);
      end
    end
  end

  // p1: registered outputs; payload only advances on an emission so stalls and gaps hold it
  always_ff @(posedge clk or negedge rst) begin : out_regs
    if (!rst) begin
      vld_p1   <= 1'b0;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
      stage_p1 <= 4'd0;
      for (int l = 0; l < 4; l++) begin
        b_p1[l]   <= 7'd0;
        sel_p1[l] <= 2'd0;
      end
    end else begin
      vld_p1  <= emit;
      busy_p1 <= (state_nxt != S_IDLE) || (state == S_DONE);
      done_p1 <= (state == S_DONE);
      if (emit) begin
        stage_p1 <= s_q;
        for (int l = 0; l < 4; l++) begin
          b_p1[l]   <= addr_of(lane_p0[l]);
          sel_p1[l] <= sel_p0[l];
        end
      end
    end
  end

  assign bus.b0      = b_p1[0];
  assign bus.b1      = b_p1[1];
  assign bus.b2      = b_p1[2];
  assign bus.b3      = b_p1[3];
  assign bus.sel_a_0 = sel_p1[0];
  assign bus.sel_a_1 = sel_p1[1];
  assign bus.sel_a_2 = sel_p1[2];
  assign bus.sel_a_3 = sel_p1[3];
  assign bus.stage   = stage_p1;
  assign bus.valid   = vld_p1;
  assign bus.busy    = busy_p1;
  assign bus.done    = done_p1;
endmodule

// File: tb/tb_ntt_addr_gen.sv
// Bench for ntt_addr_gen: timeline and emission model derived from stage/cycle arithmetic.
module tb_ntt_addr_gen;
  localparam int GAP    = 4;
  localparam int N_EMIT = 1152;
  localparam int T_DONE = 1 + N_EMIT + 8 * GAP;

  logic clk = 1'b0;
  logic rst;

  ntt_addr_gen_if bus ();

  ntt_addr_gen #(.GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [39:0] exp_last;
  int          hits [9][4][128];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] obs_vec();
    return {bus.b0, bus.b1, bus.b2, bus.b3,
            bus.sel_a_0, bus.sel_a_1, bus.sel_a_2, bus.sel_a_3, bus.stage};
  endfunction

  // Reference emission: lanes from plain integer arithmetic, then bank k -> lane lookup.
  function automatic logic [39:0] model_emit(input int s, input int c);
    int d, i0, i1, bank;
    int lane [4];
    int sel  [4];
    logic [8:0] x;
    d  = 2 ** s;
    i0 = ((2 * c) / d) * (2 * d) + (2 * c) % d;
    i1 = ((2 * c + 1) / d) * (2 * d) + (2 * c + 1) % d;
    lane[0] = i0; lane[1] = i0 + d; lane[2] = i1; lane[3] = i1 + d;
    for (int k = 0; k < 4; k++) sel[k] = 0;
    for (int l = 0; l < 4; l++) begin
      x    = 9'(lane[l]);
      bank = 2 * (lane[l] % 2) + ($countones(x) % 2);
      sel[bank] = l;
    end
    return {7'(lane[0] / 4), 7'(lane[1] / 4), 7'(lane[2] / 4), 7'(lane[3] / 4),
            2'(sel[0]), 2'(sel[1]), 2'(sel[2]), 2'(sel[3]), 4'(s)};
  endfunction

  task automatic do_reset();
    #2;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    tick();
    tick();
    #2;
    rst      = 1'b1;
    exp_last = '0;
    tick();
  endtask

  // Runs one transform from IDLE; abort_at > 0 returns right after that many emissions.
  task automatic run_transform(input string tag, input int stall_pct, input bit hold_start,
                               input int abort_at, output int done_edge, output int n_stall);
    int idx, gap_left, edge_n, n_valid;
    bit st, fin, ok;
    logic [39:0] obs, expv;
    logic [2:0]  ctl, ectl;
    logic [6:0]  bv [4];
    logic [1:0]  sv [4];
    logic [3:0]  perm;
    idx = 0; gap_left = 0; edge_n = 0; n_valid = 0; n_stall = 0; done_edge = -1; fin = 1'b0;
    for (int s = 0; s < 9; s++)
      for (int k = 0; k < 4; k++)
        for (int a = 0; a < 128; a++) hits[s][k][a] = 0;
    bus.start = 1'b1;
    bus.stall = 1'b0;
    tick();
    bus.start = hold_start;
    n_vec++;
    if (bus.busy !== 1'b1 || bus.valid !== 1'b0)
      $display("FAIL %s busy_after_start: got busy=%b valid=%b want busy=1 valid=0", tag, bus.busy, bus.valid);
    while (!fin && edge_n < 4000) begin
      st = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
      bus.stall = st;
      tick();
      edge_n++;
      if (gap_left > 0) begin
        gap_left--;
        ectl = 3'b001;
      end else if (idx < N_EMIT) begin
        if (st) begin
          n_stall++;
          ectl = 3'b001;
        end else begin
          exp_last = model_emit(idx / 128, idx % 128);
          ectl = 3'b101;
        end
      end else begin
        ectl = 3'b011;
        fin  = 1'b1;
        done_edge = edge_n;
      end
      ctl = {bus.valid, bus.done, bus.busy};
      n_vec++;
      if (ctl !== ectl) begin
        n_err++;
        $display("FAIL %s ctl edge %0d idx %0d: got {valid,done,busy}=%b want %b", tag, edge_n, idx, ctl, ectl);
      end
      obs = obs_vec();
      n_vec++;
      if (obs !== exp_last) begin
        n_err++;
        $display("FAIL %s payload edge %0d idx %0d: got %h want %h", tag, edge_n, idx, obs, exp_last);
      end
      if (ectl == 3'b101) begin
        n_valid++;
        bv[0] = bus.b0; bv[1] = bus.b1; bv[2] = bus.b2; bv[3] = bus.b3;
        sv[0] = bus.sel_a_0; sv[1] = bus.sel_a_1; sv[2] = bus.sel_a_2; sv[3] = bus.sel_a_3;
        perm = (4'b1 << sv[0]) | (4'b1 << sv[1]) | (4'b1 << sv[2]) | (4'b1 << sv[3]);
        n_vec++;
        if (perm !== 4'hF) begin
          n_err++;
          $display("FAIL %s sel_perm idx %0d: got lane mask %b want 1111", tag, idx, perm);
        end
        for (int k = 0; k < 4; k++) hits[idx / 128][k][bv[sv[k]]]++;
        if (idx == 0 || idx == 128 || idx == N_EMIT - 1) begin
          case (idx)
            0:       expv = {7'd0, 7'd0, 7'd0, 7'd0, 2'd0, 2'd2, 2'd3, 2'd1, 4'd0};
            128:     expv = {7'd0, 7'd0, 7'd0, 7'd0, 2'd0, 2'd1, 2'd3, 2'd2, 4'd1};
            default: expv = {7'd63, 7'd127, 7'd63, 7'd127, 2'd1, 2'd0, 2'd2, 2'd3, 4'd8};
          endcase
          n_vec++;
          if (obs !== expv) begin
            n_err++;
            $display("FAIL %s plan_point idx %0d: got %h want %h", tag, idx, obs, expv);
          end
        end
        idx++;
        if (idx % 128 == 0 && idx < N_EMIT) gap_left = GAP;
        if (abort_at > 0 && idx == abort_at) fin = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    n_vec++;
    if (!fin) begin
      n_err++;
      $display("FAIL %s timeout: got no completion after %0d edges want done", tag, edge_n);
    end else if (abort_at == 0) begin
      n_vec++;
      if (n_valid != N_EMIT) begin
        n_err++;
        $display("FAIL %s valid_count: got %0d want %0d", tag, n_valid, N_EMIT);
      end
      for (int s = 0; s < 9; s++) begin
        for (int k = 0; k < 4; k++) begin
          ok = 1'b1;
          for (int a = 0; a < 128; a++) if (hits[s][k][a] != 1) ok = 1'b0;
          n_vec++;
          if (!ok) begin
            n_err++;
            $display("FAIL %s bank_cover stage %0d bank %0d: got uneven address coverage want each 0..127 once", tag, s, k);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    exp_last  = '0;
    #12;
    n_vec++;
    if ({obs_vec(), bus.valid, bus.busy, bus.done} !== 43'd0) begin
      n_err++;
      $display("FAIL reset_values: got %h v%b b%b d%b want all 0", obs_vec(), bus.valid, bus.busy, bus.done);
    end
    rst = 1'b1;
    tick();
    tick();
    tick();
    n_vec++;
    if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_no_start: got {valid,busy,done}=%b want 000", {bus.valid, bus.busy, bus.done});
    end
  endtask

  task automatic test_full_run();
    int de, ns;
    run_transform("full", 0, 1'b0, 0, de, ns);
    n_vec++;
    if (de != T_DONE) begin
      n_err++;
      $display("FAIL full done_edge: got %0d want %0d", de, T_DONE);
    end
    tick();
    n_vec++;
    if ({bus.valid, bus.done, bus.busy} !== 3'b000) begin
      n_err++;
      $display("FAIL full after_done: got {valid,done,busy}=%b want 000", {bus.valid, bus.done, bus.busy});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int de, ns;
    run_transform("b2b", 0, 1'b0, 0, de, ns);
    bus.start = 1'b1;
    tick();
    n_vec++;
    if ({bus.valid, bus.done, bus.busy} !== 3'b000) begin
      n_err++;
      $display("FAIL b2b start_in_done_ignored: got {valid,done,busy}=%b want 000", {bus.valid, bus.done, bus.busy});
    end
    tick();
    bus.start = 1'b0;
    n_vec++;
    if ({bus.valid, bus.busy} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b start_next_accepted: got {valid,busy}=%b want 01", {bus.valid, bus.busy});
    end
    tick();
    n_vec++;
    if (bus.valid !== 1'b1 || obs_vec() !== model_emit(0, 0)) begin
      n_err++;
      $display("FAIL b2b first_emit: got valid=%b %h want valid=1 %h", bus.valid, obs_vec(), model_emit(0, 0));
    end
  endtask

  task automatic test_reset_mid();
    int de, ns;
    do_reset();
    run_transform("mid", 0, 1'b1, 3 * 128 + 50, de, ns);
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({obs_vec(), bus.valid, bus.busy, bus.done} !== 43'd0) begin
      n_err++;
      $display("FAIL mid async_clear: got %h v%b b%b d%b want all 0", obs_vec(), bus.valid, bus.busy, bus.done);
    end
    tick();
    tick();
    n_vec++;
    if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin
      n_err++;
      $display("FAIL mid held_in_reset: got {valid,busy,done}=%b want 000", {bus.valid, bus.busy, bus.done});
    end
    #2;
    rst      = 1'b1;
    exp_last = '0;
    tick();
    n_vec++;
    if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin
      n_err++;
      $display("FAIL mid no_done_after_abort: got {valid,busy,done}=%b want 000", {bus.valid, bus.busy, bus.done});
    end
    run_transform("restart", 0, 1'b0, 0, de, ns);
    n_vec++;
    if (de != T_DONE) begin
      n_err++;
      $display("FAIL restart done_edge: got %0d want %0d", de, T_DONE);
    end
    tick();
    tick();
  endtask

  task automatic test_stall();
    int de, ns;
    run_transform("stall", 30, 1'b0, 0, de, ns);
    n_vec++;
    if (de != T_DONE + ns) begin
      n_err++;
      $display("FAIL stall done_edge: got %0d want %0d (stalls %0d)", de, T_DONE + ns, ns);
    end
    n_vec++;
    if (ns == 0) begin
      n_err++;
      $display("FAIL stall stall_count: got 0 want nonzero");
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ntt_addr_gen.md
# ntt_addr_gen

Conflict-free address and bank-select generator for the 4-bank, 512-coefficient radix-2 NTT datapath. It sits directly upstream of the bank input crossbar. Every issue cycle it emits four per-lane bank addresses (`b0..b3`) and four bank-to-lane selects (`sel_a_0..3`) for two butterflies. The crossbar routes `b[sel_a_k]` to bank k. The block sequences all 9 stages, inserts a drain gap between stages, and supports stall back-pressure.

## Interface
- `GAP`, default 4: idle cycles inserted between consecutive stages for butterfly pipeline drain; legal range 0..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a full 9-stage transform; sampled only in IDLE.
- `stall` in 1: back-pressure; sampled in RUN only.
- `b0,b1,b2,b3` out 7: word address of lane 0..3 within its bank.
- `sel_a_0..sel_a_3` out 2: lane index whose address goes to bank 0..3.
- `stage` out 4: stage of the current emission, 0..8.
- `valid` out 1: the outputs carry a new butterfly pair this cycle.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: one-cycle pulse at the end of the transform.

## Operation
- FSM states are IDLE, RUN, GAP and DONE.
  - IDLE → RUN on `start`; stage counter `s` = 0, cycle counter `c` = 0.
  - RUN, `stall`=0:
    - register the emission for (s, c), `valid`<=1, `c`++.
    - At `c`=127: if `s`=8, go to DONE; else `s`++, `c`=0, and go to GAP, or straight to RUN again when `GAP`=0.
  - RUN, `stall`=1: counters hold, `valid`<=0, address/select/stage outputs hold their last values.
  - GAP: count `GAP` cycles with `valid`=0, then return to RUN. `stall` is ignored in GAP.
  - DONE: `done`=1 for one cycle, then IDLE.
  - `start` is ignored outside IDLE.
- Emission for (s, c):
  - Butterfly indices are j0 = 2c and j1 = 2c+1 (8-bit).
  - i = j with a zero bit inserted at bit position s (9-bit), i.e. ((j>>s)<<(s+1)) | (j & (2^s−1)).
  - d = 2^s.
  - Lane indices are lane0 = i0, lane1 = i0+d, lane2 = i1, lane3 = i1+d.
- Bank map for an index x: bank(x) = {x[0], ^x} (2 bits); address(x) = x[8:2].
  - This map is bijective over 0..511.
  - The four lanes of any emission always land in four distinct banks.
- Outputs:
  - `b_l` = address(lane l).
  - `sel_a_k` = the unique l with bank(lane l) = k (inverse permutation).
  - `stage` = s.

## Timing
- All outputs are registered.
- Reset values: `b0..b3`=0, `sel_a_0..3`=0, `stage`=0, `valid`=0, `busy`=0, `done`=0, FSM in IDLE, counters 0.
- Reset mid-transform aborts immediately to the reset state; no `done` pulse is generated.
- Timeline with start sampled at edge E0:
  - `busy` rises after E0.
  - The first `valid` cycle begins after E1.
- Per transform, `valid` is high for exactly 1152 cycles (9×128).
- Gaps total 8×`GAP` cycles and never follow stage 8.
- `done` begins the cycle immediately after the last `valid` cycle.
  - With no stall and `GAP`=4, `done` is high in the cycle after edge E0+1185.
- `busy` stays high through the `done` cycle and falls at the following edge.
- Each stall cycle extends the timeline by one cycle; no emission is lost or duplicated.
- Back-to-back transforms: `start` asserted during the `done` cycle is ignored. `start` is accepted from IDLE on the next cycle.

## Test plan
- Reset then `start`:
  - First valid: s=0, c=0 → `b`=0,0,0,0 and `sel_a`=0,2,3,1.
  - Banks per lane are 0,3,1,2.
- Stage 1 first valid: s=1, c=0, lanes 0,2,1,3 → `b`=0,0,0,0 and `sel_a`=0,1,3,2.
- Stage 8 last valid: s=8, c=127, lanes 254,510,255,511 → `b`=63,127,63,127 and `sel_a`=1,0,2,3; then `done` for 1 cycle.
- Full run with `GAP`=4, no stall:
  - Exactly 1152 `valid` cycles, with 4 invalid cycles between stages.
  - `done` lands 1185 edges after start.
  - Scoreboard: each of the 4 banks receives every address 0..127 exactly once per stage.
  - `sel_a` is always a permutation.
- Random `stall` at 30% density: the emission sequence is identical to the no-stall run; outputs hold during stalls; `done` is delayed by exactly the number of stall cycles.
- Assert `rst` low in stage 3 mid-RUN:
  - All outputs 0 asynchronously and no `done`.
  - `start` while busy is ignored.
  - A new `start` after reset restarts at s=0, c=0.
